// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// Request fields stay stable while bus_req is high; rdata/err are valid with bus_ready.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ready, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ready, bus_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns datapath load/store strobes into multi-cycle bus accesses,
// stalls the core while an access is outstanding and returns extended load data.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MisalignedFault,
  output logic        AccessFault,
  output logic        BusFault,
  load_store_unit_if.master bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_addr;
  logic [BE_W-1:0]     r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic [2:0]          r_funct3;
  logic [1:0]          r_off;
  logic [DATA_W-1:0]   r_read_data;
  logic                r_bus_fault;

  logic                w_idle;
  logic                w_one;
  logic                w_legal;
  logic                w_misaligned;
  logic                w_start;
  logic                w_timeout;
  logic [BE_W-1:0]     w_be;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_lane;
  logic [DATA_W-1:0]   w_load;

  // Request decode: legality, alignment and lane preparation from live inputs
  always_comb begin
    w_idle       = (r_state == IDLE);
    w_one        = MemRead ^ MemWrite;
    w_legal      = 1'b0;
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = WriteData;
    case (Funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = MemRead;
      default:                w_legal = 1'b0;
    endcase
    case (Funct3[1:0])
      2'b00: begin
        w_be    = 4'(4'b0001 << ALUResult[1:0]);
        w_wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        w_misaligned = ALUResult[0];
        w_be         = ALUResult[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{WriteData[15:0]}};
      end
      default: begin
        w_misaligned = |ALUResult[1:0];
        w_be         = 4'b1111;
        w_wdata      = WriteData;
      end
    endcase
    w_start = w_idle & w_one & w_legal & ~w_misaligned;
  end

  // Faults only describe the instruction being offered in IDLE
  assign AccessFault     = w_idle & ((MemRead & MemWrite) | (w_one & ~w_legal));
  assign MisalignedFault = w_idle & w_one & w_legal & w_misaligned;
  assign Stall           = w_start | (r_state == REQ);
  assign w_timeout       = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Load extension from the lane chosen by the latched byte offset
  always_comb begin
    w_lane = bus.bus_rdata >> {r_off, 3'b000};
    w_load = bus.bus_rdata;
    case (r_funct3)
      3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load = {24'd0, w_lane[7:0]};
      3'b101:  w_load = {16'd0, w_lane[15:0]};
      default: w_load = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = REQ;
      REQ:     if (bus.bus_ready || w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch, timeout counter and completion capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_read_data <= '0;
      r_bus_fault <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_addr   <= {ALUResult[31:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_we     <= MemWrite;
            r_funct3 <= Funct3;
            r_off    <= ALUResult[1:0];
            r_cnt    <= '0;
          end
        end
        REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus.bus_ready) begin
            if (!r_we) r_read_data <= w_load;
            r_bus_fault <= bus.bus_err;
          end else if (w_timeout) begin
            if (!r_we) r_read_data <= '0;
            r_bus_fault <= 1'b1;
          end
        end
        DONE: begin
          r_cnt       <= '0;
          r_bus_fault <= 1'b0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.bus_req   = (r_state == REQ);
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_be    = r_be;
  assign bus.bus_wdata = r_wdata;
  assign ReadData      = r_read_data;
  assign BusFault      = r_bus_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table driven through a bus
// responder, expected completions held in a scoreboard queue.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        Stall, MisalignedFault, AccessFault, BusFault;

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .Funct3          (Funct3),
    .ALUResult       (ALUResult),
    .WriteData       (WriteData),
    .ReadData        (ReadData),
    .Stall           (Stall),
    .MisalignedFault (MisalignedFault),
    .AccessFault     (AccessFault),
    .BusFault        (BusFault),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ready_cyc;
    logic        err;
    logic        exp_start;
    logic        exp_mis;
    logic        exp_acc;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_ld;
    logic [31:0] exp_rd;
    logic        exp_bf;
    int          exp_req;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        bf;
    int          req;
  } exp_t;

  vec_t        vt[$];
  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] model_rd = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input int rcyc, input logic err,
                     input logic st, input logic mis, input logic acc,
                     input logic [3:0] be, input logic [31:0] ewd,
                     input logic ld, input logic [31:0] erd, input logic bf,
                     input int ereq);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.ready_cyc = rcyc; v.err = err;
    v.exp_start = st; v.exp_mis = mis; v.exp_acc = acc; v.exp_be = be;
    v.exp_wdata = ewd; v.exp_ld = ld; v.exp_rd = erd; v.exp_bf = bf;
    v.exp_req = ereq;
    vt.push_back(v);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    exp_t e;
    int   reqs;
    bit   done;
    v = vt[idx];
    @(posedge clk); #1;
    MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3;
    ALUResult = v.addr; WriteData = v.wdata;
    bus.bus_ready = 1'b0; bus.bus_err = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d misaligned", idx), 32'(MisalignedFault), 32'(v.exp_mis));
    chk($sformatf("v%0d access_fault", idx), 32'(AccessFault), 32'(v.exp_acc));
    chk($sformatf("v%0d idle_stall", idx), 32'(Stall), 32'(v.exp_start));
    chk($sformatf("v%0d idle_bus_req", idx), 32'(bus.bus_req), 32'd0);
    if (v.exp_start) begin
      e.addr  = v.addr & 32'hFFFF_FFFC;
      e.be    = v.exp_be;
      e.we    = v.wr;
      e.wdata = v.exp_wdata;
      e.rd    = v.exp_ld ? v.exp_rd : model_rd;
      e.bf    = v.exp_bf;
      e.req   = v.exp_req;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    // Scramble the live inputs; only latched copies may matter from here on
    MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'($urandom);
    ALUResult = $urandom; WriteData = $urandom;
    if (!v.exp_start) begin
      @(negedge clk);
      chk($sformatf("v%0d no_req", idx), 32'(bus.bus_req), 32'd0);
      chk($sformatf("v%0d no_stall", idx), 32'(Stall), 32'd0);
      chk($sformatf("v%0d rd_kept", idx), ReadData, model_rd);
      return;
    end
    reqs = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.bus_req) begin
        reqs++;
        if (reqs == 1) begin
          chk($sformatf("v%0d bus_addr", idx), bus.bus_addr, sb_q[0].addr);
          chk($sformatf("v%0d bus_be", idx), 32'(bus.bus_be), 32'(sb_q[0].be));
          chk($sformatf("v%0d bus_we", idx), 32'(bus.bus_we), 32'(sb_q[0].we));
          chk($sformatf("v%0d bus_wdata", idx), bus.bus_wdata, sb_q[0].wdata);
        end
        chk($sformatf("v%0d req_stall c%0d", idx, reqs), 32'(Stall), 32'd1);
        if (reqs == v.ready_cyc) begin
          bus.bus_ready = 1'b1; bus.bus_rdata = v.rdata; bus.bus_err = v.err;
        end else begin
          bus.bus_ready = 1'b0; bus.bus_rdata = $urandom; bus.bus_err = 1'b0;
        end
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d done_read_data", idx), ReadData, e.rd);
        chk($sformatf("v%0d done_bus_fault", idx), 32'(BusFault), 32'(e.bf));
        chk($sformatf("v%0d done_stall", idx), 32'(Stall), 32'd0);
        chk($sformatf("v%0d req_cycles", idx), 32'(reqs), 32'(e.req));
        model_rd = e.rd;
        bus.bus_ready = 1'b0; bus.bus_err = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL v%0d completion: no DONE within 40 cycles, req cycles %0d", idx, reqs);
      bus.bus_ready = 1'b0;
      void'(sb_q.pop_front());
    end
    @(negedge clk);
    chk($sformatf("v%0d idle_bus_fault_clear", idx), 32'(BusFault), 32'd0);
    chk($sformatf("v%0d idle_read_data", idx), ReadData, model_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0;
    ALUResult = 32'd0; WriteData = 32'd0;
    bus.bus_ready = 1'b0; bus.bus_err = 1'b0; bus.bus_rdata = 32'd0;

    //  rd wr f3      addr          wdata         rdata         rc err st mis acc be       ewd           ld erd           bf req
    add(1, 0, 3'b010, 32'h100, 32'h0,         32'hDEADBEEF, 2, 0, 1, 0, 0, 4'b1111, 32'h0,         1, 32'hDEADBEEF, 0, 2);
    add(1, 0, 3'b000, 32'h103, 32'h0,         32'h80FF0000, 1, 0, 1, 0, 0, 4'b1000, 32'h0,         1, 32'hFFFFFF80, 0, 1);
    add(1, 0, 3'b100, 32'h103, 32'h0,         32'h80FF0000, 1, 0, 1, 0, 0, 4'b1000, 32'h0,         1, 32'h00000080, 0, 1);
    add(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,         1, 0, 1, 0, 0, 4'b1100, 32'hABCDABCD, 0, 32'h0,       0, 1);
    add(1, 0, 3'b010, 32'h101, 32'h0,         32'h0,         0, 0, 0, 1, 0, 4'b0000, 32'h0,         0, 32'h0,       0, 0);
    add(1, 0, 3'b001, 32'h0FF, 32'h0,         32'h0,         0, 0, 0, 1, 0, 4'b0000, 32'h0,         0, 32'h0,       0, 0);
    add(1, 0, 3'b011, 32'h100, 32'h0,         32'h0,         0, 0, 0, 0, 1, 4'b0000, 32'h0,         0, 32'h0,       0, 0);
    add(1, 1, 3'b010, 32'h100, 32'h0,         32'h0,         0, 0, 0, 0, 1, 4'b0000, 32'h0,         0, 32'h0,       0, 0);
    add(0, 1, 3'b010, 32'h202, 32'h0,         32'h0,         0, 0, 0, 1, 0, 4'b0000, 32'h0,         0, 32'h0,       0, 0);
    add(0, 1, 3'b100, 32'h100, 32'h0,         32'h0,         0, 0, 0, 0, 1, 4'b0000, 32'h0,         0, 32'h0,       0, 0);
    add(1, 0, 3'b001, 32'h102, 32'h0,         32'h80011234, 1, 0, 1, 0, 0, 4'b1100, 32'h0,         1, 32'hFFFF8001, 0, 1);
    add(1, 0, 3'b101, 32'h100, 32'h0,         32'h8001F234, 3, 0, 1, 0, 0, 4'b0011, 32'h0,         1, 32'h0000F234, 0, 3);
    add(0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h0,         2, 0, 1, 0, 0, 4'b0010, 32'hA5A5A5A5, 0, 32'h0,       0, 2);
    add(1, 0, 3'b010, 32'h040, 32'h0,         32'h0,         0, 0, 1, 0, 0, 4'b1111, 32'h0,         1, 32'h0,       1, 16);
    add(1, 0, 3'b000, 32'h001, 32'h0,         32'h00007F00, 1, 0, 1, 0, 0, 4'b0010, 32'h0,         1, 32'h0000007F, 0, 1);
    add(1, 0, 3'b010, 32'h020, 32'h0,         32'h11111111, 1, 1, 1, 0, 0, 4'b1111, 32'h0,         1, 32'h11111111, 1, 1);
    add(0, 1, 3'b010, 32'h010, 32'h12345678, 32'h0,         4, 0, 1, 0, 0, 4'b1111, 32'h12345678, 0, 32'h0,       0, 4);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset read_data", ReadData, 32'd0);
    chk("reset bus_fault", 32'(BusFault), 32'd0);
    chk("reset bus_req", 32'(bus.bus_req), 32'd0);
    chk("reset bus_be", 32'(bus.bus_be), 32'd0);
    chk("reset bus_addr", bus.bus_addr, 32'd0);
    chk("reset stall", 32'(Stall), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < vt.size(); i++) run_vec(i);

    // Reset asserted in the second REQ cycle of a load; a late ready is ignored
    chk("pre_reset read_data", ReadData, model_rd);
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h300;
    @(posedge clk); #1;
    MemRead = 1'b0;
    @(posedge clk); #1;
    chk("mid_reset req_before", 32'(bus.bus_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_reset bus_req", 32'(bus.bus_req), 32'd0);
    chk("mid_reset read_data", ReadData, 32'd0);
    chk("mid_reset stall", 32'(Stall), 32'd0);
    chk("mid_reset bus_be", 32'(bus.bus_be), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.bus_ready = 1'b1; bus.bus_rdata = 32'hCAFEF00D; bus.bus_err = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("late_ready bus_req", 32'(bus.bus_req), 32'd0);
      chk("late_ready read_data", ReadData, 32'd0);
      chk("late_ready bus_fault", 32'(BusFault), 32'd0);
    end
    bus.bus_ready = 1'b0; bus.bus_err = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the single-cycle datapath and the data-memory bus.
- Consumes the datapath's address (ALUResult), store data (WriteData) and the controller's load/store strobes, and returns sign/zero-extended load data on ReadData.
- Memory accesses take a variable number of cycles, so the block drives Stall to freeze PC and register writeback until each access completes. It also flags misaligned, illegal and bus-error accesses.

Parameters:
- TIMEOUT, 16, cycles spent in REQ without bus_ready before the access is aborted with BusFault (minimum 2).
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- MemRead  in  1  current instruction is a load
- MemWrite  in  1  current instruction is a store
- Funct3  in  3  Instr[14:12]; access size and sign
- ALUResult  in  32  byte address
- WriteData  in  32  store data (rs2)
- ReadData  out  32  extended load result to the datapath result mux
- Stall  out  1  hold PC and suppress RegWrite this cycle
- MisalignedFault  out  1  misaligned access detected (combinational, IDLE only)
- AccessFault  out  1  illegal Funct3, or MemRead and MemWrite both high
- BusFault  out  1  bus error or timeout on the completed access
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address, {ALUResult[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-aligned store data
- bus_rdata  in  32  read data, valid with bus_ready
- bus_ready  in  1  transfer complete
- bus_err  in  1  error response, valid with bus_ready

Behaviour:
- FSM states: IDLE, REQ, DONE.
- Reset: state=IDLE, ReadData=0, BusFault=0, counter=0. All bus outputs are 0 while in reset.
- IDLE, access request:
  - Condition: MemRead^MemWrite=1, Funct3 legal, and the address is aligned.
  - Latch address, be, wdata, we, Funct3 and offset; go to REQ.
  - Stall=1 combinationally in this cycle.
- Legal Funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other values set AccessFault=1.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
- IDLE, misaligned, illegal, or MemRead and MemWrite both high:
  - The relevant fault output is 1 combinationally.
  - No bus access, Stall=0, ReadData unchanged.
  - The instruction retires; trap handling belongs to the controller.
- REQ:
  - bus_req=1; latched outputs are held stable; Stall=1; counter increments each cycle.
  - On bus_ready=1: load data is captured and extended into ReadData, BusFault<=bus_err; go to DONE.
  - On counter==TIMEOUT-1 without bus_ready: BusFault<=1, ReadData<=0; go to DONE.
- DONE:
  - bus_req=0, Stall=0; the core retires the instruction at the clock edge.
  - Always go to IDLE next cycle; counter cleared.
  - BusFault stays valid during DONE and clears on IDLE entry.
- Minimum access latency: the instruction occupies 3 cycles (IDLE → REQ with ready → DONE).
- Byte enables:
  - SB/LB/LBU: be = 0001 << addr[1:0].
  - SH/LH/LHU: be = addr[1] ? 1100 : 0011.
  - Word: be = 1111.
- Store data: byte replicated ×4, halfword replicated ×2, word passed through.
- Load extension: select lane by the latched offset. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- ReadData holds its value until the next completed load. Stores never modify it.
- reset asserted mid-access: immediate return to IDLE with bus_req=0. A late bus_ready is ignored.
- Inputs may change during REQ; only the latched copies are used.

Test Plan:
- LW at 0x100, bus_ready after 2 REQ cycles, rdata=0xDEADBEEF -> bus_be=1111, Stall high for 3 cycles, ReadData=0xDEADBEEF in DONE.
- LB at 0x103 with rdata=0x80FF_0000 -> be=1000, ReadData=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x202, WriteData=0x1234ABCD, ready in 1 cycle -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, ReadData unchanged.
- LW at 0x101 -> MisalignedFault=1, bus_req never asserted, Stall=0. Same for LH at 0x0FF. Funct3=011 -> AccessFault=1.
- Load with bus_ready never asserted, TIMEOUT=16 -> 16 REQ cycles, then DONE with BusFault=1 and ReadData=0. A load with bus_err=1 on ready -> BusFault=1.
- reset driven low in the 2nd REQ cycle -> bus_req=0 immediately, state IDLE, ReadData=0. A bus_ready arriving afterwards causes no capture.
